// File: rtl/ahb_ram_bridge.sv
// AHB-Lite slave bridging onto a single-port synchronous SRAM macro (EN/WE/A/Di/Do).
// Define RAM_BRIDGE_ERR_EN to enable ERROR responses for oversized or misaligned transfers.
module ahb_ram_bridge #(
  parameter int unsigned AW = 12
) (
  input  logic          CLK,
  input  logic          RST,
  input  logic          HSEL,
  input  logic [31:0]   HADDR,
  input  logic [1:0]    HTRANS,
  input  logic          HWRITE,
  input  logic [2:0]    HSIZE,
  input  logic [31:0]   HWDATA,
  input  logic          HREADY,
  output logic          HREADYOUT,
  output logic          HRESP,
  output logic [31:0]   HRDATA,
  output logic          RAM_EN,
  output logic [3:0]    RAM_WE,
  output logic [AW-1:0] RAM_A,
  output logic [31:0]   RAM_Di,
  input  logic [31:0]   RAM_Do
);

`ifdef RAM_BRIDGE_ERR_EN
  typedef enum logic [2:0] {S_IDLE, S_WR, S_RD, S_RD_STALL, S_ERR1, S_ERR2} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_WR, S_RD, S_RD_STALL} state_t;
`endif

  state_t          state_q, state_d;
  logic [AW-1:0]   addr_q, addr_d;
  logic [3:0]      mask_q, mask_d;

  logic            accept;
  logic            bad;
  logic            rd_issue;
  logic [3:0]      lane_mask;
  logic            unused_bits;

  assign unused_bits = ^{HADDR[31:AW+2], HTRANS[0]};

  always_comb begin
    accept = HSEL & HREADY & HTRANS[1];
    case (HSIZE)
      3'd0:    lane_mask = 4'b0001 << HADDR[1:0];
      3'd1:    lane_mask = HADDR[1] ? 4'b1100 : 4'b0011;
      default: lane_mask = 4'b1111;
    endcase
`ifdef RAM_BRIDGE_ERR_EN
    bad = (HSIZE > 3'd2) || ((HSIZE == 3'd1) && HADDR[0]) ||
          ((HSIZE == 3'd2) && (HADDR[1:0] != 2'b00));
`else
    bad = 1'b0;
`endif
    // A read accepted during a write data phase is deferred to RD_STALL so the write lands first.
    rd_issue = accept && !HWRITE && !bad && (state_q != S_WR);
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    mask_d  = mask_q;
    if (accept && !bad && HWRITE) begin
      state_d = S_WR;
      addr_d  = HADDR[AW+1:2];
      mask_d  = lane_mask;
    end else if (accept && !bad && state_q == S_WR) begin
      state_d = S_RD_STALL;
      addr_d  = HADDR[AW+1:2];
    end else if (accept && !bad) begin
      state_d = S_RD;
`ifdef RAM_BRIDGE_ERR_EN
    end else if (accept) begin
      state_d = S_ERR1;
`endif
    end else begin
      case (state_q)
        S_RD_STALL: state_d = S_RD;
`ifdef RAM_BRIDGE_ERR_EN
        S_ERR1:     state_d = S_ERR2;
`endif
        default:    state_d = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= S_IDLE;
      addr_q  <= '0;
      mask_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      mask_q  <= mask_d;
    end
  end

  always_comb begin
    RAM_EN = 1'b0;
    RAM_WE = '0;
    RAM_A  = '0;
    RAM_Di = '0;
    if (state_q == S_WR) begin
      RAM_EN = 1'b1;
      RAM_WE = mask_q;
      RAM_A  = addr_q;
      RAM_Di = HWDATA;
    end else if (state_q == S_RD_STALL) begin
      RAM_EN = 1'b1;
      RAM_A  = addr_q;
    end else if (rd_issue) begin
      RAM_EN = 1'b1;
      RAM_A  = HADDR[AW+1:2];
    end
    if (RST) begin
      RAM_EN = 1'b0;
      RAM_WE = '0;
    end
  end

`ifdef RAM_BRIDGE_ERR_EN
  assign HREADYOUT = !((state_q == S_RD_STALL) || (state_q == S_ERR1));
  assign HRESP     = (state_q == S_ERR1) || (state_q == S_ERR2);
`else
  assign HREADYOUT = (state_q != S_RD_STALL);
  assign HRESP     = 1'b0;
`endif
  assign HRDATA = RAM_Do;

endmodule

// File: tb/tb_ahb_ram_bridge.sv
// Directed bench for ahb_ram_bridge with a behavioural 4Kx32 SRAM macro model.
module tb_ahb_ram_bridge;
  logic        clk = 1'b0;
  logic        rst;
  logic        hsel;
  logic [31:0] haddr;
  logic [1:0]  htrans;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [31:0] hwdata;
  logic        hready;
  logic        hreadyout;
  logic        hresp;
  logic [31:0] hrdata;
  logic        ram_en;
  logic [3:0]  ram_we;
  logic [11:0] ram_a;
  logic [31:0] ram_di;
  logic [31:0] ram_do;

  logic [31:0] mem [0:4095];
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  assign hready = hreadyout;

  ahb_ram_bridge #(.AW(12)) dut (
    .CLK(clk), .RST(rst), .HSEL(hsel), .HADDR(haddr), .HTRANS(htrans),
    .HWRITE(hwrite), .HSIZE(hsize), .HWDATA(hwdata), .HREADY(hready),
    .HREADYOUT(hreadyout), .HRESP(hresp), .HRDATA(hrdata),
    .RAM_EN(ram_en), .RAM_WE(ram_we), .RAM_A(ram_a), .RAM_Di(ram_di), .RAM_Do(ram_do)
  );

  // SRAM macro: registered read-first output, zero after a disabled cycle.
  always @(posedge clk) begin
    if (ram_en) begin
      ram_do <= mem[ram_a];
      for (int b = 0; b < 4; b++)
        if (ram_we[b]) mem[ram_a][b*8 +: 8] <= ram_di[b*8 +: 8];
    end else begin
      ram_do <= '0;
    end
  end

  task automatic drive(input logic [1:0] trans, input logic wr, input logic [2:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata);
    hsel = 1'b1; htrans = trans; hwrite = wr; hsize = size; haddr = addr; hwdata = wdata;
  endtask

  task automatic next_cycle;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    next_cycle();
    next_cycle();
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL rst_hreadyout got %0h exp 1", hreadyout); end
    checks++; if (hresp !== 1'b0) begin errors++; $display("FAIL rst_hresp got %0h exp 0", hresp); end
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL rst_ram_en got %0h exp 0", ram_en); end
    checks++; if (ram_we !== 4'h0) begin errors++; $display("FAIL rst_ram_we got %0h exp 0", ram_we); end
    checks++; if (ram_a !== 12'h0) begin errors++; $display("FAIL rst_ram_a got %0h exp 0", ram_a); end
    checks++; if (ram_di !== 32'h0) begin errors++; $display("FAIL rst_ram_di got %0h exp 0", ram_di); end
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_word_rw;
    drive(2'b10, 1'b1, 3'd2, 32'h10, 32'h0);
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL wr_addr_en got %0h exp 0", ram_en); end
    next_cycle();
    drive(2'b10, 1'b0, 3'd2, 32'h10, 32'hDEADBEEF);
    @(negedge clk);
    checks++; if (ram_we !== 4'hF) begin errors++; $display("FAIL wr_we got %0h exp f", ram_we); end
    checks++; if (ram_a !== 12'h4) begin errors++; $display("FAIL wr_a got %0h exp 4", ram_a); end
    checks++; if (ram_di !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_di got %0h exp deadbeef", ram_di); end
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL wr_hready got %0h exp 1", hreadyout); end
    next_cycle();
    drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (hreadyout !== 1'b0) begin errors++; $display("FAIL stall_hready got %0h exp 0", hreadyout); end
    checks++; if ({ram_en, ram_we, ram_a} !== {1'b1, 4'h0, 12'h4}) begin errors++; $display("FAIL stall_ram got %0h exp 10004", {ram_en, ram_we, ram_a}); end
    next_cycle();
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL rd_hready got %0h exp 1", hreadyout); end
    checks++; if (hrdata !== 32'hDEADBEEF) begin errors++; $display("FAIL rd_data got %0h exp deadbeef", hrdata); end
    next_cycle();
  endtask

  task automatic test_byte_write;
    drive(2'b10, 1'b1, 3'd2, 32'h10, 32'h0);
    next_cycle();
    drive(2'b10, 1'b1, 3'd0, 32'h13, 32'h11223344);
    next_cycle();
    drive(2'b00, 1'b0, 3'd2, 32'h0, 32'hAA000000);
    @(negedge clk);
    checks++; if (ram_we !== 4'b1000) begin errors++; $display("FAIL byte_we got %0h exp 8", ram_we); end
    checks++; if (ram_a !== 12'h4) begin errors++; $display("FAIL byte_a got %0h exp 4", ram_a); end
    next_cycle();
    drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL idle_en got %0h exp 0", ram_en); end
    next_cycle();
    drive(2'b10, 1'b0, 3'd2, 32'h10, 32'h0);
    @(negedge clk);
    checks++; if ({ram_en, ram_we, ram_a} !== {1'b1, 4'h0, 12'h4}) begin errors++; $display("FAIL byte_rd_issue got %0h exp 10004", {ram_en, ram_we, ram_a}); end
    next_cycle();
    drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL byte_rd_hready got %0h exp 1", hreadyout); end
    checks++; if (hrdata !== 32'hAA223344) begin errors++; $display("FAIL byte_rd_data got %0h exp aa223344", hrdata); end
    next_cycle();
  endtask

  task automatic test_back_to_back;
    drive(2'b10, 1'b1, 3'd2, 32'h0, 32'h0);
    next_cycle();
    drive(2'b10, 1'b1, 3'd2, 32'h4, 32'h01010101);
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL b2b_w1_hready got %0h exp 1", hreadyout); end
    checks++; if ({ram_we, ram_a} !== {4'hF, 12'h0}) begin errors++; $display("FAIL b2b_w1_ram got %0h exp f000", {ram_we, ram_a}); end
    next_cycle();
    drive(2'b10, 1'b0, 3'd2, 32'h0, 32'h02020202);
    @(negedge clk);
    checks++; if (hreadyout !== 1'b1) begin errors++; $display("FAIL b2b_w2_hready got %0h exp 1", hreadyout); end
    checks++; if ({ram_we, ram_a, ram_di} !== {4'hF, 12'h1, 32'h02020202}) begin errors++; $display("FAIL b2b_w2_ram got %0h exp f00102020202", {ram_we, ram_a, ram_di}); end
    next_cycle();
    drive(2'b10, 1'b0, 3'd2, 32'h4, 32'h0);
    @(negedge clk);
    checks++; if (hreadyout !== 1'b0) begin errors++; $display("FAIL b2b_stall got %0h exp 0", hreadyout); end
    checks++; if ({ram_en, ram_a} !== {1'b1, 12'h0}) begin errors++; $display("FAIL b2b_stall_ram got %0h exp 1000", {ram_en, ram_a}); end
    next_cycle();
    @(negedge clk);
    checks++; if ({hreadyout, hrdata} !== {1'b1, 32'h01010101}) begin errors++; $display("FAIL b2b_r1 got %0h exp 101010101", {hreadyout, hrdata}); end
    checks++; if ({ram_en, ram_a} !== {1'b1, 12'h1}) begin errors++; $display("FAIL b2b_r2_issue got %0h exp 1001", {ram_en, ram_a}); end
    next_cycle();
    drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if ({hreadyout, hrdata} !== {1'b1, 32'h02020202}) begin errors++; $display("FAIL b2b_r2 got %0h exp 102020202", {hreadyout, hrdata}); end
    next_cycle();
  endtask

  task automatic test_reset_during_write;
    drive(2'b10, 1'b1, 3'd2, 32'h8, 32'h0);
    next_cycle();
    drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h12345678);
    next_cycle();
    drive(2'b10, 1'b1, 3'd2, 32'h8, 32'h0);
    next_cycle();
    rst = 1'b1;
    drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h5);
    @(negedge clk);
    checks++; if ({ram_en, ram_we} !== 5'h0) begin errors++; $display("FAIL rstwr_ram got %0h exp 0", {ram_en, ram_we}); end
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    checks++; if ({hreadyout, hresp, ram_en} !== 3'b100) begin errors++; $display("FAIL rstwr_after got %0h exp 4", {hreadyout, hresp, ram_en}); end
    next_cycle();
    drive(2'b10, 1'b0, 3'd2, 32'h8, 32'h0);
    @(negedge clk);
    checks++; if ({ram_en, ram_a} !== {1'b1, 12'h2}) begin errors++; $display("FAIL rstwr_rd_issue got %0h exp 1002", {ram_en, ram_a}); end
    next_cycle();
    drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if (hrdata !== 32'h12345678) begin errors++; $display("FAIL rstwr_old_data got %0h exp 12345678", hrdata); end
    next_cycle();
  endtask

  task automatic test_err;
    drive(2'b10, 1'b0, 3'd1, 32'h1, 32'h0);
`ifdef RAM_BRIDGE_ERR_EN
    @(negedge clk);
    checks++; if ({hreadyout, hresp, ram_en} !== 3'b100) begin errors++; $display("FAIL err_addr got %0h exp 4", {hreadyout, hresp, ram_en}); end
    next_cycle();
    drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if ({hreadyout, hresp, ram_en} !== 3'b010) begin errors++; $display("FAIL err1 got %0h exp 2", {hreadyout, hresp, ram_en}); end
    next_cycle();
    @(negedge clk);
    checks++; if ({hreadyout, hresp, ram_en} !== 3'b110) begin errors++; $display("FAIL err2 got %0h exp 6", {hreadyout, hresp, ram_en}); end
    next_cycle();
    @(negedge clk);
    checks++; if ({hreadyout, hresp} !== 2'b10) begin errors++; $display("FAIL err_done got %0h exp 2", {hreadyout, hresp}); end
`else
    @(negedge clk);
    checks++; if ({hreadyout, hresp, ram_en, ram_a} !== {3'b101, 12'h0}) begin errors++; $display("FAIL mis_issue got %0h exp 5000", {hreadyout, hresp, ram_en, ram_a}); end
    next_cycle();
    drive(2'b00, 1'b0, 3'd2, 32'h0, 32'h0);
    @(negedge clk);
    checks++; if ({hreadyout, hresp, hrdata} !== {2'b10, 32'h01010101}) begin errors++; $display("FAIL mis_data got %0h exp 201010101", {hreadyout, hresp, hrdata}); end
`endif
    next_cycle();
  endtask

  task automatic test_idle;
    drive(2'b00, 1'b0, 3'd2, 32'h10, 32'h0);
    @(negedge clk);
    checks++; if ({hreadyout, hresp, ram_en} !== 3'b100) begin errors++; $display("FAIL idle_xfer got %0h exp 4", {hreadyout, hresp, ram_en}); end
    next_cycle();
    drive(2'b01, 1'b1, 3'd2, 32'h10, 32'h0);
    @(negedge clk);
    checks++; if ({hreadyout, hresp, ram_en} !== 3'b100) begin errors++; $display("FAIL busy_xfer got %0h exp 4", {hreadyout, hresp, ram_en}); end
    next_cycle();
    @(negedge clk);
    checks++; if (ram_en !== 1'b0) begin errors++; $display("FAIL busy_no_wr got %0h exp 0", ram_en); end
    next_cycle();
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = '0;
    ram_do = '0;
    test_reset();
    test_word_rw();
    test_byte_write();
    test_back_to_back();
    test_reset_during_write();
    test_err();
    test_idle();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/ahb_ram_bridge.md
# ahb_ram_bridge

AHB-Lite slave that sits directly upstream of the 4K×32 single-port synchronous SRAM macro. It translates bus transfers into the macro's EN / WE[3:0] / A / Di / Do port protocol. Reads complete with zero wait states; writes are performed in the AHB data phase. A read that collides with a pending write takes one wait state.

## Interface
- AW, 12, RAM word-address width; the bridge decodes HADDR[AW+1:2]
- CLK  in  1  system clock, all logic on rising edge
- RST  in  1  synchronous, active-high reset
- HSEL  in  1  slave select
- HADDR  in  32  byte address
- HTRANS  in  2  transfer type; bit 1 set = NONSEQ/SEQ
- HWRITE  in  1  1 = write
- HSIZE  in  3  0 = byte, 1 = half, 2 = word
- HWDATA  in  32  write data, valid in the data phase
- HREADY  in  1  bus-level ready
- HREADYOUT  out  1  slave ready
- HRESP  out  1  0 = OKAY, 1 = ERROR
- HRDATA  out  32  read data
- RAM_EN  out  1  macro enable
- RAM_WE  out  4  byte write enables
- RAM_A  out  AW  macro word address
- RAM_Di  out  32  macro write data
- RAM_Do  in  32  macro read data; registered, and 0 one cycle after an EN=0 edge

## Operation
- Accept condition: HSEL & HREADY & HTRANS[1]. IDLE/BUSY transfers get a zero-wait OKAY and no RAM access.
- Byte lanes:
  - HSIZE=0: WE = 1<<HADDR[1:0]
  - HSIZE=1: WE = HADDR[1] ? 1100 : 0011
  - HSIZE=2: WE = 1111
- FSM states: IDLE, WR, RD, RD_STALL, ERR1, ERR2.
- Accepted read, state ≠ WR:
  - Same cycle: RAM_EN=1, RAM_WE=0, RAM_A=HADDR[AW+1:2] (combinational).
  - Next state RD.
- Accepted write:
  - Latch word address and lane mask.
  - Next state WR.
- WR:
  - RAM_EN=1, RAM_WE=latched mask, RAM_A=latched address, RAM_Di=HWDATA, HREADYOUT=1.
  - A read accepted in this cycle is latched, not issued; next state RD_STALL.
  - A write accepted in this cycle goes to WR again (back-to-back writes, no wait).
- RD_STALL:
  - RAM_EN=1, RAM_WE=0, RAM_A=latched read address, HREADYOUT=0.
  - Next state RD.
- RD:
  - HRDATA=RAM_Do, HREADYOUT=1.
  - A new accepted transfer is handled per the rules above.
- Read-after-write to the same address returns the new data. The write reaches the macro before the read is issued, so no forwarding is needed.
- HRDATA is driven from RAM_Do in every state. It is meaningful only in RD.

## Timing
- Reset values: state IDLE, HREADYOUT=1, HRESP=0, RAM_EN=0, RAM_WE=0, RAM_A=0, RAM_Di=0, latched address/mask=0.
- While RST=1, RAM_EN and RAM_WE are forced to 0 combinationally.
  - A write whose data phase coincides with reset is dropped.
  - A stalled read is abandoned.
- Latency, measured from the address-phase edge:
  - Read: data valid 1 cycle later (0 wait states); 2 cycles when it follows a write (1 wait state).
  - Write: RAM updated at the end of the data phase.
- RAM_EN is deasserted in any cycle with no read issue and no WR state, so idle cycles do not toggle the macro.
- Wait-state rule: HREADYOUT is low only in RD_STALL and ERR1. While HREADYOUT is low, HREADY is low and no new transfer is accepted.

## Configuration
- RAM_BRIDGE_ERR_EN defined:
  - A transfer with HSIZE>2, or misaligned (HSIZE=1 with HADDR[0]=1, or HSIZE=2 with HADDR[1:0]≠0), performs no RAM access.
  - It gets a two-cycle ERROR: ERR1 (HREADYOUT=0, HRESP=1), then ERR2 (HREADYOUT=1, HRESP=1).
  - Next state after ERR2 is IDLE, or the handling of any transfer accepted in ERR2.
  - A write data phase in progress when the bad address is accepted still completes.
- RAM_BRIDGE_ERR_EN undefined:
  - HRESP is tied to 0 and ERR1/ERR2 are absent.
  - HSIZE>2 is treated as a word.
  - Misaligned transfers use the lane mask that the HSIZE and HADDR[1:0] rules above give them, with no error.

## Test plan
- Word write of 0xDEADBEEF to 0x0000_0010, then read of 0x10 → write data phase has RAM_WE=1111, RAM_A=4; read data phase has one wait state, then HRDATA=0xDEADBEEF.
- Byte write of 0xAA to 0x13 over word 0x11223344 at 0x10, then a read issued after an IDLE cycle → RAM_WE=1000; zero-wait read returns 0xAA223344.
- Two back-to-back word writes to 0x0 and 0x4, then two back-to-back reads → HREADYOUT stays 1 for both writes; the first read has one wait state, the second none; data matches.
- RST asserted during the data phase of a write of 0x5 to 0x8, then read 0x8 after reset → RAM_EN=0 in the reset cycle; read returns the old contents; HREADYOUT=1 and HRESP=0 after reset.
- With RAM_BRIDGE_ERR_EN: half-word read at 0x1 → ERR1 then ERR2 (HRESP=1 both cycles, HREADYOUT 0 then 1), RAM_EN=0 throughout. Without the macro → OKAY, zero wait states, RAM_A=0.
- IDLE transfer with HSEL=1 → HREADYOUT=1, HRESP=0, RAM_EN=0.
